seq_chain: RTL and testbench



---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_debounce.sv | 59 +++++
 rtl/seq_chain.sv | 129 ++++++++++++
 tb/tb_seq_chain.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the seq_chain antenna-path sequencer.
//   - seq_state_e    : 2-bit sequencer FSM state
//   - DEFAULT_INVERT : default per-stage polarity (stage 0 is an LNA-type stage)
//   - timer_width()  : width of the inter-stage step timer
package seq_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      KEY_UP   = 2'd1,
      TX       = 2'd2,
      KEY_DOWN = 2'd3
   } seq_state_e;

   localparam logic [15:0] DEFAULT_INVERT = 16'h0001;

   // The timer counts STEP_CYCLES-1 down to 0, so clog2(STEP_CYCLES) bits
   // suffice; STEP_CYCLES=1 still needs a one-bit vector.
   function automatic int unsigned timer_width(input int unsigned step_cycles);
      return (step_cycles > 1) ? $clog2(step_cycles) : 1;
   endfunction

endpackage

// File: rtl/seq_debounce.sv
// seq_debounce: PTT input conditioning.
//   clk     in  system clock
//   reset   in  synchronous, active-low
//   ptt     in  asynchronous push-to-talk, active-low
//   ptt_req out 1 = transmit requested (synchronised and debounced)
// A 2-flop synchroniser feeds a disagreement counter; ptt_req flips on the
// edge after the synchronised level has disagreed with it for
// DEBOUNCE_CYCLES consecutive samples.
module seq_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic ptt,
   output logic ptt_req
);

   localparam int unsigned CNT_W = 8;

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ptt_req_q, ptt_req_d;
   logic             want_tx;

   assign want_tx = ~sync2_q;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      cnt_d     = '0;
      ptt_req_d = ptt_req_q;
      if (want_tx != ptt_req_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            ptt_req_d = want_tx;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge values, exactly like the hardware.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= '0;
         ptt_req_q <= 1'b0;
      end else begin
         sync1_q   <= ptt;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         ptt_req_q <= ptt_req_d;
      end
   end

   assign ptt_req = ptt_req_q;

endmodule

// File: rtl/seq_chain.sv
// seq_chain: parametrised TX/RX antenna-path sequencer.
//   clk       in  system clock
//   reset     in  synchronous, active-low
//   ptt       in  asynchronous push-to-talk, active-low
//   inhibit   in  1 forces RX (acts like a PTT release)
//   stage_out out NUM_STAGES registered stage drives (act ^ INVERT)
//   tx_ready  out 1 while every stage is active
//   busy      out 1 while stepping stages up or down
// Active stages always form a contiguous prefix, so stepping is a one-bit
// shift of the active vector: at most one stage changes per edge.
module seq_chain
   import seq_pkg::*;
#(
   parameter int unsigned               NUM_STAGES      = 3,
   parameter int unsigned               STEP_CYCLES     = 5,
   parameter int unsigned               DEBOUNCE_CYCLES = 2,
   parameter logic [NUM_STAGES-1:0]     INVERT          = NUM_STAGES'(DEFAULT_INVERT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ptt,
   input  logic                  inhibit,
   output logic [NUM_STAGES-1:0] stage_out,
   output logic                  tx_ready,
   output logic                  busy
);

   localparam int unsigned           TIMER_W      = timer_width(STEP_CYCLES);
   localparam logic [TIMER_W-1:0]    TIMER_RELOAD = TIMER_W'(STEP_CYCLES - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ON       = '1;

   seq_state_e              state_q, state_d;
   logic [NUM_STAGES-1:0]   act_q, act_d;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic [NUM_STAGES-1:0]   stage_out_q;
   logic                    tx_ready_q;
   logic                    ptt_req, tx_req, timer_done;
   logic [NUM_STAGES-1:0]   act_up, act_dn;

   seq_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .ptt    (ptt),
      .ptt_req(ptt_req)
   );

   assign tx_req     = ptt_req & ~inhibit;
   assign timer_done = (timer_q == '0);
   assign act_up     = {act_q[NUM_STAGES-2:0], 1'b1};  // activate lowest inactive
   assign act_dn     = act_q >> 1;                      // drop highest active

   // Any direction change steps immediately and restarts the timer.
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      timer_d = timer_q;
      unique case (state_q)
         RX_IDLE: begin
            if (tx_req) begin
               act_d   = NUM_STAGES'(1);
               timer_d = TIMER_RELOAD;
               state_d = KEY_UP;
            end
         end
         KEY_UP: begin
            if (!tx_req) begin
               act_d   = act_dn;
               timer_d = TIMER_RELOAD;
               state_d = (act_dn == '0) ? RX_IDLE : KEY_DOWN;
            end else if (timer_done) begin
               act_d   = act_up;
               timer_d = TIMER_RELOAD;
               state_d = (act_up == ALL_ON) ? TX : KEY_UP;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         TX: begin
            if (!tx_req) begin
               act_d   = act_dn;
               timer_d = TIMER_RELOAD;
               state_d = KEY_DOWN;
            end
         end
         KEY_DOWN: begin
            if (tx_req) begin
               act_d   = act_up;
               timer_d = TIMER_RELOAD;
               state_d = (act_up == ALL_ON) ? TX : KEY_UP;
            end else if (timer_done) begin
               act_d   = act_dn;
               timer_d = TIMER_RELOAD;
               state_d = (act_dn == '0) ? RX_IDLE : KEY_DOWN;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = RX_IDLE;
            act_d   = '0;
         end
      endcase
   end

   // NOTE: reset drops every stage at once (no reverse ordering) and drives
   // the outputs to their RX polarity.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RX_IDLE;
         act_q       <= '0;
         timer_q     <= '0;
         stage_out_q <= INVERT;
         tx_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         timer_q     <= timer_d;
         stage_out_q <= act_d ^ INVERT;
         tx_ready_q  <= (state_d == TX);
      end
   end

   assign stage_out = stage_out_q;
   assign tx_ready  = tx_ready_q;
   assign busy      = (state_q == KEY_UP) || (state_q == KEY_DOWN);

endmodule

// File: tb/tb_seq_chain.sv
// tb_seq_chain: self-checking bench for seq_chain at default parameters.
// A level-based reference model (number of active stages moving toward a
// target) is compared every clock, plus directed timing checks.
module tb_seq_chain;

   localparam int         N    = 3;
   localparam int         STEP = 5;
   localparam int         DEB  = 2;
   localparam logic [2:0] INV  = 3'b001;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ptt = 1'b1;
   logic       inhibit = 1'b0;
   logic [2:0] stage_out;
   logic       tx_ready;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic saw_tx = 1'b0;

   // reference model state
   bit m_s1 = 1'b1, m_s2 = 1'b1, m_req = 1'b0;
   int m_streak = 0, m_n = 0, m_wait = 0, m_dir = 0;

   seq_chain #(
      .NUM_STAGES     (N),
      .STEP_CYCLES    (STEP),
      .DEBOUNCE_CYCLES(DEB),
      .INVERT         (INV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ptt      (ptt),
      .inhibit  (inhibit),
      .stage_out(stage_out),
      .tx_ready (tx_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge of the behavioural model: sample pre-edge values only.
   task automatic model_edge();
      bit tx_req, want;
      int target, d;
      if (!reset) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_req = 1'b0;
         m_streak = 0; m_n = 0; m_wait = 0; m_dir = 0;
         return;
      end
      tx_req = m_req && !inhibit;
      target = tx_req ? N : 0;
      if (m_n != target) begin
         d = (target > m_n) ? 1 : -1;
         if (m_n == 0 || m_n == N || d != m_dir || m_wait == 0) begin
            m_n    = m_n + d;
            m_wait = STEP - 1;
            m_dir  = d;
         end else begin
            m_wait = m_wait - 1;
         end
      end
      want = (m_s2 == 1'b0);
      if (want != m_req) begin
         m_streak++;
         if (m_streak == DEB + 1) begin
            m_req    = want;
            m_streak = 0;
         end
      end else begin
         m_streak = 0;
      end
      m_s2 = m_s1;
      m_s1 = ptt;
   endtask

   task automatic tick();
      logic [2:0] exp_out;
      @(posedge clk);
      model_edge();
      #1;
      exp_out = 3'((1 << m_n) - 1) ^ INV;
      check("model_stage_out", 32'(stage_out), 32'(exp_out));
      check("model_tx_ready", 32'(tx_ready), 32'(m_n == N));
      check("model_busy", 32'(busy), 32'(m_n > 0 && m_n < N));
      saw_tx = saw_tx | tx_ready;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // reset
      reset = 1'b0; ptt = 1'b1; inhibit = 1'b0;
      ticks(2);
      check("reset_stage_out", 32'(stage_out), 32'(3'b001));
      check("reset_tx_ready", 32'(tx_ready), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      reset = 1'b1;
      ticks(3);

      // key-up: stage 0 at edge 5, 1 at 10, 2 at 15
      ptt = 1'b0;
      ticks(5);  check("ku_e4", 32'(stage_out), 32'(3'b001));
      tick();    check("ku_e5", 32'(stage_out), 32'(3'b000));
      ticks(4);  check("ku_e9", 32'(stage_out), 32'(3'b000));
      tick();    check("ku_e10", 32'(stage_out), 32'(3'b010));
                 check("ku_e10_busy", 32'(busy), 32'(1));
      ticks(4);  check("ku_e14_txr", 32'(tx_ready), 32'(0));
      tick();    check("ku_e15", 32'(stage_out), 32'(3'b110));
                 check("ku_e15_txr", 32'(tx_ready), 32'(1));
                 check("ku_e15_busy", 32'(busy), 32'(0));
      ticks(3);

      // key-down from TX
      ptt = 1'b1;
      ticks(5);  check("kd_e4", 32'(stage_out), 32'(3'b110));
      tick();    check("kd_e5", 32'(stage_out), 32'(3'b010));
      ticks(5);  check("kd_e10", 32'(stage_out), 32'(3'b000));
      ticks(4);  check("kd_e14_busy", 32'(busy), 32'(1));
      tick();    check("kd_e15", 32'(stage_out), 32'(3'b001));
                 check("kd_e15_busy", 32'(busy), 32'(0));
      ticks(5);

      // abort: ptt low for 10 clocks, then released
      saw_tx = 1'b0;
      ptt = 1'b0;
      ticks(10); check("ab_e9", 32'(stage_out), 32'(3'b000));
      ptt = 1'b1;
      tick();    check("ab_e10", 32'(stage_out), 32'(3'b010));
      ticks(4);  check("ab_e14", 32'(stage_out), 32'(3'b010));
      tick();    check("ab_e15", 32'(stage_out), 32'(3'b000));
      ticks(4);  check("ab_e19", 32'(stage_out), 32'(3'b000));
      tick();    check("ab_e20", 32'(stage_out), 32'(3'b001));
      check("ab_no_tx_ready", 32'(saw_tx), 32'(0));
      ticks(5);

      // one-clock glitch
      ptt = 1'b0;
      tick();
      ptt = 1'b1;
      ticks(8);  check("glitch", 32'(stage_out), 32'(3'b001));

      // inhibit holds RX, dropping it keys up on the next edge
      inhibit = 1'b1; ptt = 1'b0;
      ticks(12); check("inh_hold", 32'(stage_out), 32'(3'b001));
                 check("inh_busy", 32'(busy), 32'(0));
      inhibit = 1'b0;
      tick();    check("inh_release", 32'(stage_out), 32'(3'b000));
      ticks(5);  check("inh_stage1", 32'(stage_out), 32'(3'b010));

      // reset mid-KEY_UP
      reset = 1'b0;
      tick();    check("midrst_out", 32'(stage_out), 32'(3'b001));
                 check("midrst_busy", 32'(busy), 32'(0));
      reset = 1'b1; ptt = 1'b1;
      ticks(6);

      // randomized phase, checked against the model every clock
      for (int i = 0; i < 80; i++) begin
         ptt     = 1'($urandom_range(0, 1));
         inhibit = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 20) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         ticks($urandom_range(1, 25));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
